pipe_run_controller: RTL and testbench
======================================

// Module: pipe_run_controller
// PURPOSE
//   Sequences the pipelined processor through reset, run and halt, then streams a post-run
//   snapshot of data memory (words 0..MEM_WORDS-1) followed by the register file (0..REG_COUNT-1).
//   Sits between the top level and processor datapath; replaces fixed-cycle-count bench
//   sequencing with a self-terminating, handshaked dump.
// PARAMETERS
//   DATA_W        32  width of memory/register words
//   MEM_WORDS     64  data-memory words dumped (addr width 6)
//   REG_COUNT     32  registers dumped (addr width 5)
//   RESET_CYCLES   2  cycles proc_reset held high after start
//   MAX_CYCLES    32  run-cycle limit before forced stop (timeout)
//   DRAIN_CYCLES   4  cycles proc_en stays high after halt_seen so in-flight instrs retire
// PORTS
//   clk          in   1       clock, all state on rising edge
//   reset        in   1       asynchronous, active-high
//   start        in   1       pulse; accepted only in IDLE or DONE
//   halt_seen    in   1       processor WB stage retired halt instruction
//   proc_reset   out  1       reset to processor
//   proc_en      out  1       processor clock enable (0 = freeze all pipeline regs)
//   mem_addr     out  6       data-memory debug read address (combinational read port)
//   mem_rdata    in   DATA_W  data-memory debug read data
//   reg_addr     out  5       register-file debug read address (combinational read port)
//   reg_rdata    in   DATA_W  register-file debug read data
//   dump_valid   out  1       dump word available
//   dump_ready   in   1       consumer accepts word
//   dump_data    out  DATA_W  dump word (registered)
//   dump_is_reg  out  1       0 = memory word, 1 = register
//   dump_index   out  6       word index within its region
//   busy         out  1       high in every state except IDLE and DONE
//   done         out  1       high in DONE
//   timeout      out  1       sticky: run ended by MAX_CYCLES, cleared on accepted start
// BEHAVIOUR
//   Reset values: proc_reset=1, proc_en=0, dump_valid=0, dump_data=0, addrs/index=0,
//     dump_is_reg=0, busy=0, done=0, timeout=0; state=IDLE. Reset mid-operation aborts at once.
//   States: IDLE -> RST -> RUN -> DRAIN -> DUMP_MEM -> DUMP_REG -> DONE.
//   IDLE: proc_reset=1, proc_en=0; start -> RST, clears timeout.
//   RST: proc_reset=1 for exactly RESET_CYCLES cycles, then RUN with cycle counter=0.
//   RUN: proc_reset=0, proc_en=1, counter +1 per cycle. halt_seen -> DRAIN. Else counter
//     reaching MAX_CYCLES-1 -> DUMP_MEM with timeout=1 (skips DRAIN). halt_seen and limit in
//     same cycle: halt wins, timeout stays 0.
//   DRAIN: proc_en=1 for DRAIN_CYCLES cycles, halt_seen ignored, then DUMP_MEM.
//   DUMP_*: proc_en=0 (processor frozen, state preserved). Per word, two phases:
//     FETCH (1 cycle): address driven, dump_valid=0; rdata captured into dump_data.
//     PRESENT: dump_valid=1, dump_data/dump_index/dump_is_reg stable until dump_valid&dump_ready.
//     On handshake: last index -> next region (MEM->REG at index 0, REG->DONE), else index+1
//     and back to FETCH. Max throughput 1 word / 2 cycles; ready held low stalls indefinitely.
//   DONE: done=1, proc_reset=0, proc_en=0 (state left for inspection); start -> RST.
//   start while busy is ignored. Index counters saturate at region end; no wrap.
// TESTING
//   1 start; halt_seen at run cycle 10, ready=1 -> proc_reset high 2 cyc; proc_en high 11+4
//     cyc; 64 mem then 32 reg words, idx 0..63 / 0..31, done=1, timeout=0.
//   2 start; halt_seen never -> proc_en high exactly 32 cyc, no DRAIN, timeout=1, full dump.
//   3 Backpressure: ready low 5 cyc on mem word 7 -> dump_data/index held, no skip/duplicate,
//     proc_en stays 0.
//   4 halt_seen asserted on cycle 31 (limit) -> DRAIN taken, timeout=0.
//   5 reset during DUMP_REG idx 12 -> all outputs to reset values next sample; new start
//     re-runs from RST, dump restarts at mem idx 0.
//   6 start pulsed while busy -> ignored; start in DONE -> timeout cleared, new run begins.

Source files
------------

// File: rtl/pipe_run_controller.sv
// Run controller for the pipelined processor: reset, run until halt or cycle limit, drain,
// then stream a handshaked snapshot of data memory followed by the register file.
module pipe_run_controller #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_WORDS    = 64,
  parameter int unsigned REG_COUNT    = 32,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 32,
  parameter int unsigned DRAIN_CYCLES = 4,
  localparam int unsigned MEM_AW = $clog2(MEM_WORDS),
  localparam int unsigned REG_AW = $clog2(REG_COUNT),
  localparam int unsigned IDX_W  = (MEM_AW > REG_AW) ? MEM_AW : REG_AW
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              halt_seen_i,
  output logic              proc_reset_o,
  output logic              proc_en_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [REG_AW-1:0] reg_addr_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_is_reg_o,
  output logic [IDX_W-1:0]  dump_index_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o
);

  localparam int unsigned CNT_MAX = (MAX_CYCLES > RESET_CYCLES) ?
                                    ((MAX_CYCLES > DRAIN_CYCLES) ? MAX_CYCLES : DRAIN_CYCLES) :
                                    ((RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_RUN, S_DRAIN, S_DUMP_MEM, S_DUMP_REG, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                present_q, present_d;
  logic                timeout_q, timeout_d;
  logic                proc_reset_q, proc_reset_d;
  logic                proc_en_q, proc_en_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [REG_AW-1:0]   reg_addr_q, reg_addr_d;
  logic                dump_valid_q, dump_valid_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;
  logic                dump_is_reg_q, dump_is_reg_d;
  logic [IDX_W-1:0]    dump_index_q, dump_index_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      present_q     <= 1'b0;
      timeout_q     <= 1'b0;
      proc_reset_q  <= 1'b1;
      proc_en_q     <= 1'b0;
      mem_addr_q    <= '0;
      reg_addr_q    <= '0;
      dump_valid_q  <= 1'b0;
      dump_data_q   <= '0;
      dump_is_reg_q <= 1'b0;
      dump_index_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      present_q     <= present_d;
      timeout_q     <= timeout_d;
      proc_reset_q  <= proc_reset_d;
      proc_en_q     <= proc_en_d;
      mem_addr_q    <= mem_addr_d;
      reg_addr_q    <= reg_addr_d;
      dump_valid_q  <= dump_valid_d;
      dump_data_q   <= dump_data_d;
      dump_is_reg_q <= dump_is_reg_d;
      dump_index_q  <= dump_index_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Sequencing; registered outputs are decoded from the next state so they track state_q.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    present_d   = present_q;
    timeout_d   = timeout_q;
    dump_data_d = dump_data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d   = S_RST;
          cnt_d     = '0;
          idx_d     = '0;
          present_d = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_RST: begin
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (halt_seen_i) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d   = S_DUMP_MEM;
          timeout_d = 1'b1;
          idx_d     = '0;
          present_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_d   = S_DUMP_MEM;
          idx_d     = '0;
          present_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DUMP_MEM, S_DUMP_REG: begin
        if (!present_q) begin
          // Read ports are combinational: the address registered last cycle is valid now.
          present_d   = 1'b1;
          dump_data_d = (state_q == S_DUMP_MEM) ? mem_rdata_i : reg_rdata_i;
        end else if (dump_ready_i) begin
          present_d = 1'b0;
          if (state_q == S_DUMP_MEM && idx_q == IDX_W'(MEM_WORDS - 1)) begin
            state_d = S_DUMP_REG;
            idx_d   = '0;
          end else if (state_q == S_DUMP_REG && idx_q == IDX_W'(REG_COUNT - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    proc_reset_d  = (state_d == S_IDLE) || (state_d == S_RST);
    proc_en_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
    busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d        = (state_d == S_DONE);
    dump_valid_d  = ((state_d == S_DUMP_MEM) || (state_d == S_DUMP_REG)) && present_d;
    dump_is_reg_d = (state_d == S_DUMP_REG);
    dump_index_d  = idx_d;
    mem_addr_d    = (state_d == S_DUMP_MEM) ? idx_d[MEM_AW-1:0] : mem_addr_q;
    reg_addr_d    = (state_d == S_DUMP_REG) ? idx_d[REG_AW-1:0] : reg_addr_q;
  end

  assign proc_reset_o  = proc_reset_q;
  assign proc_en_o     = proc_en_q;
  assign mem_addr_o    = mem_addr_q;
  assign reg_addr_o    = reg_addr_q;
  assign dump_valid_o  = dump_valid_q;
  assign dump_data_o   = dump_data_q;
  assign dump_is_reg_o = dump_is_reg_q;
  assign dump_index_o  = dump_index_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_pipe_run_controller.sv
// Bench for pipe_run_controller: randomized memory/register contents and handshake timing,
// checked against a run-length and dump-order model derived from the controller's rules.
module tb_pipe_run_controller;

  localparam int unsigned DATA_W = 32;
  localparam int MEM_N = 64;
  localparam int REG_N = 32;
  localparam int MAXC  = 32;
  localparam int DRAIN = 4;
  localparam int RSTC  = 2;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              start_i;
  logic              halt_seen_i;
  logic              proc_reset_o;
  logic              proc_en_o;
  logic [5:0]        mem_addr_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic [4:0]        reg_addr_o;
  logic [DATA_W-1:0] reg_rdata_i;
  logic              dump_valid_o;
  logic              dump_ready_i;
  logic [DATA_W-1:0] dump_data_o;
  logic              dump_is_reg_o;
  logic [5:0]        dump_index_o;
  logic              busy_o;
  logic              done_o;
  logic              timeout_o;

  logic [DATA_W-1:0] mem_m [MEM_N];
  logic [DATA_W-1:0] reg_m [REG_N];

  int checks = 0;
  int failures = 0;

  // Observations of the most recent run
  int r_rst, r_en, r_words, r_bad_words, r_bad_hold, r_en_dump, r_stalls;
  bit r_tclr, r_done, r_timeout, r_hung, r_aborted;

  always #5 clk = ~clk;

  assign mem_rdata_i = mem_m[mem_addr_o];
  assign reg_rdata_i = reg_m[reg_addr_o];

  pipe_run_controller dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .halt_seen_i(halt_seen_i),
    .proc_reset_o(proc_reset_o), .proc_en_o(proc_en_o),
    .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .reg_addr_o(reg_addr_o), .reg_rdata_i(reg_rdata_i),
    .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i), .dump_data_o(dump_data_o),
    .dump_is_reg_o(dump_is_reg_o), .dump_index_o(dump_index_o),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o)
  );

  // Drives one start-to-done session and records what happened; scenarios judge the result.
  // mode: 0 ready always high, 1 random ready, 2 ready low for 5 cycles on mem word 7.
  task automatic run_once(input int halt_at, input int mode, input int abort_reg_idx,
                          input int busy_start_cyc);
    bit stalled = 1'b0;
    logic [DATA_W-1:0] h_data = '0;
    logic [5:0] h_idx = '0;
    logic h_isreg = 1'b0;
    int cyc = 0;
    int n;
    bit exp_isreg;
    int exp_idx;
    logic [DATA_W-1:0] exp_data;
    foreach (mem_m[i]) mem_m[i] = $urandom;
    foreach (reg_m[i]) reg_m[i] = $urandom;
    r_rst = 0; r_en = 0; r_words = 0; r_bad_words = 0; r_bad_hold = 0; r_en_dump = 0;
    r_stalls = 0; r_tclr = 1'b0; r_hung = 1'b0; r_aborted = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    while (cyc < 3000) begin
      if (cyc == 0) r_tclr = (timeout_o == 1'b0) && (busy_o == 1'b1);
      if (done_o) break;
      if (proc_reset_o && busy_o) r_rst++;
      halt_seen_i = 1'b0;
      if (proc_en_o) begin
        if (r_en == halt_at) halt_seen_i = 1'b1;
        else if (r_en > halt_at) halt_seen_i = 1'($urandom_range(0, 1));
        r_en++;
      end
      if (stalled) begin
        if (!dump_valid_o || dump_data_o !== h_data || dump_index_o !== h_idx ||
            dump_is_reg_o !== h_isreg)
          r_bad_hold++;
      end
      if (dump_valid_o && proc_en_o) r_en_dump++;
      if (abort_reg_idx >= 0 && dump_valid_o && dump_is_reg_o &&
          int'(dump_index_o) == abort_reg_idx) begin
        reset_i = 1'b1;
        r_aborted = 1'b1;
        return;
      end
      case (mode)
        0: dump_ready_i = 1'b1;
        1: dump_ready_i = 1'($urandom_range(0, 1));
        default: begin
          dump_ready_i = 1'b1;
          if (dump_valid_o && !dump_is_reg_o && dump_index_o == 6'd7 && r_stalls < 5) begin
            dump_ready_i = 1'b0;
            r_stalls++;
          end
        end
      endcase
      if (dump_valid_o && dump_ready_i) begin
        n = r_words;
        exp_isreg = (n >= MEM_N);
        exp_idx   = exp_isreg ? n - MEM_N : n;
        exp_data  = exp_isreg ? reg_m[exp_idx % REG_N] : mem_m[exp_idx % MEM_N];
        if (dump_is_reg_o !== exp_isreg || int'(dump_index_o) != exp_idx ||
            dump_data_o !== exp_data)
          r_bad_words++;
        r_words++;
      end
      stalled = dump_valid_o && !dump_ready_i;
      h_data = dump_data_o; h_idx = dump_index_o; h_isreg = dump_is_reg_o;
      start_i = (cyc == busy_start_cyc);
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    halt_seen_i = 1'b0;
    r_hung = (cyc >= 3000);
    r_done = done_o;
    r_timeout = timeout_o;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({proc_reset_o, proc_en_o, dump_valid_o, dump_is_reg_o, busy_o, done_o, timeout_o}
        !== 7'b1000000 || dump_data_o !== '0 || mem_addr_o !== '0 || reg_addr_o !== '0 ||
        dump_index_o !== '0) begin
      failures++;
      $display("FAIL reset_values got rst=%b en=%b v=%b busy=%b done=%b to=%b data=%h idx=%0d",
               proc_reset_o, proc_en_o, dump_valid_o, busy_o, done_o, timeout_o, dump_data_o,
               dump_index_o);
    end
    reset_i = 1'b0;
    @(negedge clk);
    checks++;
    if (proc_reset_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold got rst=%b busy=%b done=%b exp 1/0/0", proc_reset_o, busy_o, done_o);
    end
  endtask

  task automatic test_halt_run();
    run_once(10, 0, -1, -1);
    checks++;
    if (r_rst != RSTC) begin
      failures++; $display("FAIL halt_run proc_reset_cycles got=%0d exp=%0d", r_rst, RSTC);
    end
    checks++;
    if (r_en != 11 + DRAIN) begin
      failures++; $display("FAIL halt_run proc_en_cycles got=%0d exp=%0d", r_en, 11 + DRAIN);
    end
    checks++;
    if (r_words != MEM_N + REG_N || r_bad_words != 0 || r_hung) begin
      failures++;
      $display("FAIL halt_run dump got words=%0d bad=%0d hung=%0d exp 96/0/0",
               r_words, r_bad_words, r_hung);
    end
    checks++;
    if (r_done !== 1'b1 || r_timeout !== 1'b0) begin
      failures++; $display("FAIL halt_run status got done=%b to=%b exp 1/0", r_done, r_timeout);
    end
  endtask

  task automatic test_timeout();
    run_once(1000, 0, -1, -1);
    checks++;
    if (r_en != MAXC) begin
      failures++; $display("FAIL timeout proc_en_cycles got=%0d exp=%0d", r_en, MAXC);
    end
    checks++;
    if (r_timeout !== 1'b1 || r_done !== 1'b1) begin
      failures++; $display("FAIL timeout status got to=%b done=%b exp 1/1", r_timeout, r_done);
    end
    checks++;
    if (r_words != MEM_N + REG_N || r_bad_words != 0 || r_hung) begin
      failures++; $display("FAIL timeout dump got words=%0d bad=%0d", r_words, r_bad_words);
    end
  endtask

  task automatic test_backpressure();
    run_once($urandom_range(0, 20), 2, -1, -1);
    checks++;
    if (r_stalls != 5 || r_bad_hold != 0) begin
      failures++; $display("FAIL backpressure hold got stalls=%0d bad_hold=%0d exp 5/0",
                           r_stalls, r_bad_hold);
    end
    checks++;
    if (r_words != MEM_N + REG_N || r_bad_words != 0 || r_en_dump != 0 || r_hung) begin
      failures++; $display("FAIL backpressure dump got words=%0d bad=%0d en_in_dump=%0d",
                           r_words, r_bad_words, r_en_dump);
    end
  endtask

  task automatic test_halt_at_limit();
    run_once(MAXC - 1, 0, -1, -1);
    checks++;
    if (r_en != MAXC + DRAIN || r_timeout !== 1'b0) begin
      failures++; $display("FAIL halt_at_limit got en=%0d to=%b exp %0d/0",
                           r_en, r_timeout, MAXC + DRAIN);
    end
  endtask

  task automatic test_reset_in_dump();
    run_once(5, 0, 12, -1);
    #1;
    checks++;
    if (!r_aborted || r_words != MEM_N + 12) begin
      failures++; $display("FAIL reset_in_dump reach got aborted=%b words=%0d exp 1/%0d",
                           r_aborted, r_words, MEM_N + 12);
    end
    checks++;
    if ({proc_reset_o, proc_en_o, dump_valid_o, dump_is_reg_o, busy_o, done_o, timeout_o}
        !== 7'b1000000 || dump_data_o !== '0 || dump_index_o !== '0 || mem_addr_o !== '0 ||
        reg_addr_o !== '0) begin
      failures++; $display("FAIL reset_in_dump values got rst=%b en=%b v=%b reg=%b busy=%b idx=%0d",
                           proc_reset_o, proc_en_o, dump_valid_o, dump_is_reg_o, busy_o,
                           dump_index_o);
    end
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    run_once(7, 1, -1, -1);
    checks++;
    if (r_rst != RSTC || r_en != 8 + DRAIN || r_words != MEM_N + REG_N || r_bad_words != 0 ||
        r_hung) begin
      failures++; $display("FAIL reset_in_dump rerun got rst=%0d en=%0d words=%0d bad=%0d",
                           r_rst, r_en, r_words, r_bad_words);
    end
  endtask

  task automatic test_start_while_busy();
    int h;
    run_once(1000, 0, -1, -1);
    h = $urandom_range(0, 20);
    run_once(h, 1, -1, 25);
    checks++;
    if (r_tclr !== 1'b1) begin
      failures++; $display("FAIL start_in_done timeout_clear got=%b exp 1", r_tclr);
    end
    checks++;
    if (r_rst != RSTC || r_en != h + 1 + DRAIN || r_words != MEM_N + REG_N ||
        r_bad_words != 0 || r_timeout !== 1'b0 || r_done !== 1'b1 || r_hung) begin
      failures++; $display("FAIL start_while_busy got rst=%0d en=%0d words=%0d bad=%0d to=%b",
                           r_rst, r_en, r_words, r_bad_words, r_timeout);
    end
  endtask

  task automatic test_random_runs();
    int h, exp_en;
    bit exp_to;
    for (int k = 0; k < 5; k++) begin
      h = $urandom_range(0, 40);
      exp_to = (h >= MAXC);
      exp_en = exp_to ? MAXC : h + 1 + DRAIN;
      run_once(h, 1, -1, -1);
      checks++;
      if (r_en != exp_en || r_timeout !== exp_to || r_words != MEM_N + REG_N ||
          r_bad_words != 0 || r_bad_hold != 0 || r_en_dump != 0 || r_hung) begin
        failures++;
        $display("FAIL random_run%0d halt=%0d got en=%0d to=%b words=%0d bad=%0d hold=%0d exp en=%0d to=%b",
                 k, h, r_en, r_timeout, r_words, r_bad_words, r_bad_hold, exp_en, exp_to);
      end
    end
  endtask

  initial begin
    reset_i = 1'b1;
    start_i = 1'b0;
    halt_seen_i = 1'b0;
    dump_ready_i = 1'b0;
    test_reset();
    test_halt_run();
    test_timeout();
    test_backpressure();
    test_halt_at_limit();
    test_reset_in_dump();
    test_start_while_busy();
    test_random_runs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
